// File: rtl/cache_bank_param_if.sv
// Bus bundle for cache_bank_param: both ports' request and response signals,
// plus the bank-level status.
//   master : cache controller / core side (drives requests, sees responses)
//   slave  : the cache bank
// Signals per port x in {A,B}:
//   cacheDataIn_x, cacheAddressIn_x, memWrite_x (0 = write, 1 = read) -> bank
//   cacheDataOut_x, portx_writtenTo                                  <- bank
// Bank status: bankReady, writeCollision                             <- bank
interface cache_bank_param_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] cacheDataIn_A;
  logic [ADDR_WIDTH-1:0] cacheAddressIn_A;
  logic                  memWrite_A;
  logic [DATA_WIDTH-1:0] cacheDataOut_A;
  logic                  portA_writtenTo;

  logic [DATA_WIDTH-1:0] cacheDataIn_B;
  logic [ADDR_WIDTH-1:0] cacheAddressIn_B;
  logic                  memWrite_B;
  logic [DATA_WIDTH-1:0] cacheDataOut_B;
  logic                  portB_writtenTo;

  logic                  bankReady;
  logic                  writeCollision;

  modport master (
    output cacheDataIn_A, cacheAddressIn_A, memWrite_A,
    output cacheDataIn_B, cacheAddressIn_B, memWrite_B,
    input  cacheDataOut_A, portA_writtenTo,
    input  cacheDataOut_B, portB_writtenTo,
    input  bankReady, writeCollision
  );

  modport slave (
    input  cacheDataIn_A, cacheAddressIn_A, memWrite_A,
    input  cacheDataIn_B, cacheAddressIn_B, memWrite_B,
    output cacheDataOut_A, portA_writtenTo,
    output cacheDataOut_B, portB_writtenTo,
    output bankReady, writeCollision
  );
endinterface

// File: rtl/cache_bank_param.sv
// Parametrised dual-port cache bank with per-line "written" flags.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous active-low reset
//   bus   : cache_bank_param_if.slave (two read/write ports, bankReady,
//           writeCollision)
// Behaviour: 1-cycle registered reads, read-before-write between ports,
// port A wins when both ports write the same line (writeCollision pulses).
// Optional feature macro: CACHE_BANK_ZERO_INIT_EN adds a post-reset INIT
// sweep that zero-fills every line before bankReady rises.
module cache_bank_param #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  cache_bank_param_if.slave   bus
);

  localparam int unsigned LINES = 2 ** ADDR_WIDTH;

`ifdef CACHE_BANK_ZERO_INIT_EN
  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } bankState_t;

  bankState_t            state;
  logic [ADDR_WIDTH-1:0] sweepAddr;
`endif

  logic [DATA_WIDTH-1:0] lineStore [LINES];
  logic [LINES-1:0]      isWritten;

  logic                  ready;
  logic [DATA_WIDTH-1:0] dataOutA;
  logic [DATA_WIDTH-1:0] dataOutB;
  logic                  writtenA;
  logic                  writtenB;
  logic                  collision;

  logic                  writeA_c;
  logic                  writeB_c;
  logic                  sameAddrWrite_c;

  // Decoded write requests (memWrite is active-low).
  assign writeA_c        = ~bus.memWrite_A;
  assign writeB_c        = ~bus.memWrite_B;
  assign sameAddrWrite_c = writeA_c & writeB_c &
                           (bus.cacheAddressIn_A == bus.cacheAddressIn_B);

  // Line store: no reset; accesses in a reset cycle are discarded.
  always_ff @(posedge clk) begin
    if (reset) begin
`ifdef CACHE_BANK_ZERO_INIT_EN
      if (state == INIT) begin
        lineStore[sweepAddr] <= '0;
      end
`endif
      if (ready) begin
        // Port A has priority on a same-line double write.
        if (writeB_c && !sameAddrWrite_c) begin
          lineStore[bus.cacheAddressIn_B] <= bus.cacheDataIn_B;
        end
        if (writeA_c) begin
          lineStore[bus.cacheAddressIn_A] <= bus.cacheDataIn_A;
        end
      end
    end
  end

  // Control, flags and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
`ifdef CACHE_BANK_ZERO_INIT_EN
      state     <= INIT;
      sweepAddr <= '0;
`endif
      ready     <= 1'b0;
      isWritten <= '0;
      dataOutA  <= '0;
      dataOutB  <= '0;
      writtenA  <= 1'b0;
      writtenB  <= 1'b0;
      collision <= 1'b0;
    end else begin
      collision <= 1'b0;
      if (ready) begin
        // Reads see pre-edge contents, giving read-before-write ordering.
        if (!writeA_c) begin
          dataOutA <= lineStore[bus.cacheAddressIn_A];
          writtenA <= isWritten[bus.cacheAddressIn_A];
        end
        if (!writeB_c) begin
          dataOutB <= lineStore[bus.cacheAddressIn_B];
          writtenB <= isWritten[bus.cacheAddressIn_B];
        end
        if (writeA_c) begin
          isWritten[bus.cacheAddressIn_A] <= 1'b1;
        end
        if (writeB_c) begin
          isWritten[bus.cacheAddressIn_B] <= 1'b1;
        end
        collision <= sameAddrWrite_c;
      end
`ifdef CACHE_BANK_ZERO_INIT_EN
      case (state)
        INIT: begin
          sweepAddr <= sweepAddr + ADDR_WIDTH'(1);
          if (sweepAddr == ADDR_WIDTH'(LINES - 1)) begin
            state <= RUN;
            ready <= 1'b1;
          end
        end
        default: begin
          state <= RUN;
        end
      endcase
`else
      ready <= 1'b1;
`endif
    end
  end

  assign bus.cacheDataOut_A  = dataOutA;
  assign bus.cacheDataOut_B  = dataOutB;
  assign bus.portA_writtenTo = writtenA;
  assign bus.portB_writtenTo = writtenB;
  assign bus.bankReady       = ready;
  assign bus.writeCollision  = collision;

endmodule

// File: tb/tb_cache_bank_param.sv
// Self-checking bench for cache_bank_param: directed scenarios followed by
// randomized traffic, all checked against a line-level reference model.
module tb_cache_bank_param;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 8;
  localparam int unsigned LINES = 256;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cache_bank_param_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  cache_bank_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Reference model state
  logic [DW-1:0] mMem     [LINES];
  bit            mKnown   [LINES];
  bit            mWritten [LINES];
  logic [DW-1:0] expA, expB;
  bit            knownA, knownB, expWA, expWB, expReady, expColl;
  int            sweepIdx;

  int checksTotal  = 0;
  int checksPassed = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checksTotal++;
    assert (obs === exp) checksPassed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic checkAll(input string tag);
    chk({tag, "/ready"},     32'(bus.bankReady),       32'(expReady));
    chk({tag, "/collision"}, 32'(bus.writeCollision),  32'(expColl));
    chk({tag, "/writtenA"},  32'(bus.portA_writtenTo), 32'(expWA));
    chk({tag, "/writtenB"},  32'(bus.portB_writtenTo), 32'(expWB));
    if (knownA) chk({tag, "/dataA"}, bus.cacheDataOut_A, expA);
    if (knownB) chk({tag, "/dataB"}, bus.cacheDataOut_B, expB);
  endtask

  // One clock: drive, advance the model at the edge, then compare.
  task automatic step(input bit rst,
                      input bit wA, input logic [AW-1:0] aA, input logic [DW-1:0] dA,
                      input bit wB, input logic [AW-1:0] aB, input logic [DW-1:0] dB,
                      input string tag);
    bit coll;
    reset                = rst;
    bus.memWrite_A       = ~wA;
    bus.cacheAddressIn_A = aA;
    bus.cacheDataIn_A    = dA;
    bus.memWrite_B       = ~wB;
    bus.cacheAddressIn_B = aB;
    bus.cacheDataIn_B    = dB;
    @(posedge clk);
    if (!rst) begin
      for (int i = 0; i < int'(LINES); i++) mWritten[i] = 1'b0;
      expA = '0; expB = '0; knownA = 1'b1; knownB = 1'b1;
      expWA = 1'b0; expWB = 1'b0; expReady = 1'b0; expColl = 1'b0;
      sweepIdx = 0;
    end else if (expReady) begin
      coll = wA && wB && (aA == aB);
      if (!wA) begin expA = mMem[aA]; knownA = mKnown[aA]; expWA = mWritten[aA]; end
      if (!wB) begin expB = mMem[aB]; knownB = mKnown[aB]; expWB = mWritten[aB]; end
      if (wB) begin
        if (!coll) begin mMem[aB] = dB; mKnown[aB] = 1'b1; end
        mWritten[aB] = 1'b1;
      end
      if (wA) begin mMem[aA] = dA; mKnown[aA] = 1'b1; mWritten[aA] = 1'b1; end
      expColl = coll;
    end else begin
      expColl = 1'b0;
`ifdef CACHE_BANK_ZERO_INIT_EN
      mMem[sweepIdx]   = '0;
      mKnown[sweepIdx] = 1'b1;
      sweepIdx++;
      if (sweepIdx == int'(LINES)) expReady = 1'b1;
`else
      expReady = 1'b1;
`endif
    end
    #1;
    checkAll(tag);
  endtask

  task automatic idle(input string tag);
    step(1'b1, 1'b0, 8'h00, 32'h0, 1'b0, 8'h00, 32'h0, tag);
  endtask

  // Steps until the DUT reports ready; returns the number of steps taken.
  task automatic waitReady(input int bound, output int cnt);
    cnt = 0;
    while (bus.bankReady !== 1'b1 && cnt < bound) begin
      idle("waitReady");
      cnt++;
    end
    chk("readyWithinBound", 32'(bus.bankReady), 32'd1);
  endtask

  initial begin
    int cnt;
    for (int i = 0; i < int'(LINES); i++) begin
      mMem[i] = '0; mKnown[i] = 1'b0; mWritten[i] = 1'b0;
    end
    reset = 1'b0;
    bus.memWrite_A = 1'b1; bus.memWrite_B = 1'b1;
    bus.cacheAddressIn_A = '0; bus.cacheAddressIn_B = '0;
    bus.cacheDataIn_A = '0; bus.cacheDataIn_B = '0;

    // Reset state
    step(1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 8'h00, 32'h0, "reset0");
    step(1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 8'h00, 32'h0, "reset1");
    chk("resetDataA", bus.cacheDataOut_A, 32'h0);
    chk("resetReady", 32'(bus.bankReady), 32'd0);
    waitReady(LINES + 8, cnt);
`ifdef CACHE_BANK_ZERO_INIT_EN
    chk("readyLatency", 32'(cnt), 32'(LINES));
`else
    chk("readyLatency", 32'(cnt), 32'd1);
`endif

    // Write then read back on A; B reads a never-written line
    step(1'b1, 1'b1, 8'h10, 32'hDEADBEEF, 1'b0, 8'h20, 32'h0, "wrA10");
    chk("neverWrittenB", 32'(bus.portB_writtenTo), 32'd0);
`ifdef CACHE_BANK_ZERO_INIT_EN
    chk("zeroFilledB", bus.cacheDataOut_B, 32'h0);
`endif
    step(1'b1, 1'b0, 8'h10, 32'h0, 1'b0, 8'h20, 32'h0, "rdA10");
    chk("readA10", bus.cacheDataOut_A, 32'hDEADBEEF);
    chk("writtenA10", 32'(bus.portA_writtenTo), 32'd1);

    // Same-line double write: A wins, one-cycle collision pulse
    step(1'b1, 1'b1, 8'h05, 32'h11111111, 1'b1, 8'h05, 32'h22222222, "collide");
    chk("collisionPulse", 32'(bus.writeCollision), 32'd1);
    idle("afterCollide");
    chk("collisionClear", 32'(bus.writeCollision), 32'd0);
    step(1'b1, 1'b0, 8'h05, 32'h0, 1'b0, 8'h05, 32'h0, "rd05");
    chk("collideWinner", bus.cacheDataOut_A, 32'h11111111);

    // Read-before-write across ports
    step(1'b1, 1'b1, 8'h07, 32'h12345678, 1'b0, 8'h00, 32'h0, "pre07");
    step(1'b1, 1'b1, 8'h07, 32'hAAAA0000, 1'b0, 8'h07, 32'h0, "rbw07");
    chk("rbwOld", bus.cacheDataOut_B, 32'h12345678);
    step(1'b1, 1'b0, 8'h00, 32'h0, 1'b0, 8'h07, 32'h0, "rd07");
    chk("rbwNew", bus.cacheDataOut_B, 32'hAAAA0000);

    // Fill 0..3, reset pulse clears flags and outputs
    step(1'b1, 1'b1, 8'h00, 32'hA0A0A0A0, 1'b1, 8'h01, 32'hB1B1B1B1, "fill01");
    step(1'b1, 1'b1, 8'h02, 32'hC2C2C2C2, 1'b1, 8'h03, 32'hD3D3D3D3, "fill23");
    step(1'b1, 1'b0, 8'h02, 32'h0, 1'b0, 8'h03, 32'h0, "rdFill");
    chk("fillDataB", bus.cacheDataOut_B, 32'hD3D3D3D3);
    step(1'b0, 1'b1, 8'h09, 32'h99999999, 1'b0, 8'h02, 32'h0, "midReset");
    chk("midResetOutA", bus.cacheDataOut_A, 32'h0);
    chk("midResetReady", 32'(bus.bankReady), 32'd0);
    waitReady(LINES + 8, cnt);
    step(1'b1, 1'b0, 8'h00, 32'h0, 1'b0, 8'h01, 32'h0, "rdAfterRst01");
    chk("flagCleared0", 32'(bus.portA_writtenTo), 32'd0);
    step(1'b1, 1'b0, 8'h02, 32'h0, 1'b0, 8'h03, 32'h0, "rdAfterRst23");
    chk("flagCleared3", 32'(bus.portB_writtenTo), 32'd0);
    step(1'b1, 1'b0, 8'h09, 32'h0, 1'b0, 8'h09, 32'h0, "rdDiscarded09");
    chk("resetCycleWriteDropped", 32'(bus.portA_writtenTo), 32'd0);

`ifdef CACHE_BANK_ZERO_INIT_EN
    // Sweep restart and writes ignored during INIT
    step(1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 8'h00, 32'h0, "sweepReset");
    for (int i = 0; i < 'h80; i++)
      step(1'b1, 1'b1, 8'h30, 32'h5A5A5A5A, 1'b1, 8'h31, 32'hA5A5A5A5, "sweepWrites");
    step(1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 8'h00, 32'h0, "resetAt80");
    waitReady(LINES + 8, cnt);
    chk("sweepRestartLen", 32'(cnt), 32'(LINES));
    step(1'b1, 1'b0, 8'h30, 32'h0, 1'b0, 8'h31, 32'h0, "rdInitWrites");
    chk("initWriteFlagA", 32'(bus.portA_writtenTo), 32'd0);
    chk("initWriteDataB", bus.cacheDataOut_B, 32'h0);
`endif

    // Randomized traffic on a small address window to provoke conflicts
    for (int i = 0; i < 400; i++) begin
      bit rst;
      rst = ($urandom_range(0, 99) != 0);
      step(rst,
           1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom(),
           1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom(),
           "random");
    end

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule

// File: doc/cache_bank_param.md
# cache_bank_param

Parametrised dual-port cache bank: the next-generation successor to the fixed 256 x 32 cache bank. It provides two independent read/write ports over a flop-based line store. It also tracks a per-line "written" flag, so the cache controller can tell stale lines from filled lines. Same-cycle port conflicts are arbitrated deterministically, and an optional post-reset zero-fill sweep is available. It sits between the cache controller and the core-side load/store ports.

## Interface
- DATA_WIDTH, 32, line width in bits
- ADDR_WIDTH, 8, address width; LINES = 2**ADDR_WIDTH
- clk  input  1  single clock, all logic on rising edge
- reset  input  1  synchronous, active-low reset
- cacheDataIn_A  input  DATA_WIDTH  port A write data
- cacheAddressIn_A  input  ADDR_WIDTH  port A line address
- memWrite_A  input  1  active-low write enable (0 = write, 1 = read)
- cacheDataOut_A  output  DATA_WIDTH  port A registered read data
- portA_writtenTo  output  1  registered written-flag of the line read on A
- cacheDataIn_B, cacheAddressIn_B, memWrite_B, cacheDataOut_B, portB_writtenTo: same as the port A signals, for port B
- bankReady  output  1  bank accepts accesses
- writeCollision  output  1  one-cycle pulse: both ports wrote the same address

## Operation
- Storage: LINES x DATA_WIDTH array plus a LINES-bit isWritten vector.
- FSM states:
  - INIT: zero-fill sweep, present only with the macro.
  - RUN: normal operation.
- Reset (reset=0 at an edge):
  - State goes to INIT (macro) or RUN (no macro); bankReady=0.
  - isWritten cleared to all 0.
  - cacheDataOut_A/B=0, portA/B_writtenTo=0, writeCollision=0.
  - Line contents are untouched by reset itself.
- Reset asserted mid-operation or mid-sweep: same as above; any access in that cycle is discarded; the sweep restarts from 0.
- RUN, per port each cycle:
  - Write (memWrite_x=0): store data, set isWritten[addr]=1. That port's outputs hold their previous values.
  - Read (memWrite_x=1): cacheDataOut_x <= line[addr], portx_writtenTo <= isWritten[addr].
- Accesses presented while bankReady=0 are ignored: no store, no flag change, outputs hold.
- Both ports write the same address in one cycle:
  - Port A data is stored and port B data is dropped.
  - writeCollision=1 for exactly the following cycle; otherwise it is 0.
- One port writes an address while the other reads it in the same cycle: the read returns the old data and the old flag (read-before-write). No forwarding.
- Different addresses on the two ports are fully independent.
- Address width is exact; no wrap or bounds logic is needed.

## Timing
- Read latency: 1 cycle. The address is sampled at edge N; data and flag are valid after edge N.
- A write at edge N is visible to reads sampled at edge N+1 or later, on either port.
- Outputs change only on read cycles or reset.
- bankReady without the macro: rises after the first edge with reset=1.
- bankReady with the macro: rises after the edge that writes line LINES-1, i.e. LINES edges after reset release.

## Configuration
- CACHE_BANK_ZERO_INIT_EN
- Defined:
  - After reset release the FSM sits in INIT and writes 0 to lines 0..LINES-1, one per cycle, via an internal counter.
  - isWritten stays 0 (zero-fill does not count as written).
  - bankReady=0 for the whole sweep.
- Undefined:
  - No INIT state; contents are undefined after power-up until written.
  - The isWritten flags still report reliably which lines have been written.

## Test plan
- Reset, then A writes 0xDEADBEEF to 0x10; next cycle A reads 0x10 -> cacheDataOut_A=0xDEADBEEF, portA_writtenTo=1 one cycle later.
- B reads never-written 0x20 -> portB_writtenTo=0. With the macro, cacheDataOut_B=0 and bankReady first rises 256 cycles after reset release.
- Same cycle, A writes 0x11111111 and B writes 0x22222222, both to 0x05 -> writeCollision pulses 1 cycle; a later read of 0x05 returns 0x11111111.
- Same cycle, A writes 0xAAAA0000 to 0x07 (previously 0x12345678) and B reads 0x07 -> B gets 0x12345678. A B read of 0x07 on the next cycle gets 0xAAAA0000.
- Fill 0x00..0x03, then pulse reset low 1 cycle -> all outputs 0, bankReady=0; reads of 0x00..0x03 report writtenTo=0.
- Macro on: assert reset at sweep address 0x80 -> sweep restarts at 0x00. Writes presented during INIT are dropped (their addresses read writtenTo=0 afterwards).
